// File: rtl/morra_controllo_torneo.sv
// Tournament sequencer for the morra cinese evaluator: collects the two moves,
// issues them, consumes the round verdict and tracks manche, partite and tournament.
module morra_controllo_torneo #(
    parameter int unsigned MIN_MANCHE = 4,
    parameter int unsigned MAX_MANCHE = 20,
    parameter int unsigned SCARTO     = 2,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       INIZIA,
    input  logic [3:0] CFG_PARTITE,
    input  logic       P1_VALID,
    input  logic [1:0] P1_MOSSA,
    output logic       P1_READY,
    input  logic       P2_VALID,
    input  logic [1:0] P2_MOSSA,
    output logic       P2_READY,
    output logic       MOSSA_VALID,
    output logic [1:0] MOSSA_PRIMO,
    output logic [1:0] MOSSA_SECONDO,
    input  logic       MANCHE_VALID,
    input  logic [1:0] MANCHE_IN,
    output logic [1:0] PARTITA,
    output logic       PARTITA_VALID,
    output logic [4:0] MANCHE_GIOCATE,
    output logic [4:0] PARTITE_PRIMO,
    output logic [4:0] PARTITE_SECONDO,
    output logic [1:0] TORNEO,
    output logic       TORNEO_FINE,
    output logic       ERRORE
);

    typedef enum logic [2:0] {
        IDLE,
        RACCOLTA,
        INVIO,
        ATTESA,
        AGGIORNA,
        FINE_PARTITA,
        FINE
    } stato_t;

    localparam int unsigned TW    = $clog2(TIMEOUT + 1);
    localparam logic [4:0]  MIN_M = 5'(MIN_MANCHE);
    localparam logic [4:0]  MAX_M = 5'(MAX_MANCHE);
    localparam logic [4:0]  SCA   = 5'(SCARTO);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    stato_t        stato, stato_n;
    logic [1:0]    slot1, slot1_n, slot2, slot2_n;
    logic [4:0]    n_tot, n_tot_n;
    logic [4:0]    mg, mg_n, w1, w1_n, w2, w2_n;
    logic [4:0]    pp, pp_n, ps, ps_n, pg, pg_n;
    logic [1:0]    esito, esito_n, torneo, torneo_n, verdetto, verdetto_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          errore, errore_n;

    logic [4:0]    mg_agg, w1_agg, w2_agg, scarto_agg;
    logic [4:0]    pp_fine, ps_fine, pg_fine;
    logic [1:0]    esito_agg;
    logic          chiude;

    always_ff @(posedge clk) begin
        if (rst) begin
            stato    <= IDLE;
            slot1    <= '0;
            slot2    <= '0;
            n_tot    <= '0;
            mg       <= '0;
            w1       <= '0;
            w2       <= '0;
            pp       <= '0;
            ps       <= '0;
            pg       <= '0;
            esito    <= '0;
            torneo   <= '0;
            verdetto <= '0;
            tcnt     <= '0;
            errore   <= 1'b0;
        end else begin
            stato    <= stato_n;
            slot1    <= slot1_n;
            slot2    <= slot2_n;
            n_tot    <= n_tot_n;
            mg       <= mg_n;
            w1       <= w1_n;
            w2       <= w2_n;
            pp       <= pp_n;
            ps       <= ps_n;
            pg       <= pg_n;
            esito    <= esito_n;
            torneo   <= torneo_n;
            verdetto <= verdetto_n;
            tcnt     <= tcnt_n;
            errore   <= errore_n;
        end
    end

    always_comb begin
        stato_n    = stato;
        slot1_n    = slot1;
        slot2_n    = slot2;
        n_tot_n    = n_tot;
        mg_n       = mg;
        w1_n       = w1;
        w2_n       = w2;
        pp_n       = pp;
        ps_n       = ps;
        pg_n       = pg;
        esito_n    = esito;
        torneo_n   = torneo;
        verdetto_n = verdetto;
        tcnt_n     = tcnt;
        errore_n   = 1'b0;

        // Post-update round totals, so the close check sees this round's verdict
        mg_agg = mg;
        w1_agg = w1;
        w2_agg = w2;
        if (verdetto != 2'b00) mg_agg = mg + 5'd1;
        if (verdetto == 2'b01) w1_agg = w1 + 5'd1;
        if (verdetto == 2'b10) w2_agg = w2 + 5'd1;
        scarto_agg = (w1_agg >= w2_agg) ? (w1_agg - w2_agg) : (w2_agg - w1_agg);
        chiude     = (verdetto != 2'b00) &&
                     (((mg_agg >= MIN_M) && (scarto_agg >= SCA)) || (mg_agg == MAX_M));
        if (w1_agg > w2_agg)      esito_agg = 2'b01;
        else if (w1_agg < w2_agg) esito_agg = 2'b10;
        else                      esito_agg = 2'b11;

        pp_fine = pp + {4'b0, esito == 2'b01};
        ps_fine = ps + {4'b0, esito == 2'b10};
        pg_fine = pg + 5'd1;

        if (INIZIA) begin
            n_tot_n    = {1'b0, CFG_PARTITE} + 5'd1;
            slot1_n    = '0;
            slot2_n    = '0;
            mg_n       = '0;
            w1_n       = '0;
            w2_n       = '0;
            pp_n       = '0;
            ps_n       = '0;
            pg_n       = '0;
            esito_n    = '0;
            torneo_n   = '0;
            verdetto_n = '0;
            tcnt_n     = '0;
            stato_n    = RACCOLTA;
        end else begin
            case (stato)
                RACCOLTA: begin
                    // A 00 move is accepted but leaves the slot empty
                    if (P1_VALID && (slot1 == 2'b00)) slot1_n = P1_MOSSA;
                    if (P2_VALID && (slot2 == 2'b00)) slot2_n = P2_MOSSA;
                    if ((slot1_n != 2'b00) && (slot2_n != 2'b00)) stato_n = INVIO;
                end
                INVIO: begin
                    tcnt_n  = '0;
                    stato_n = ATTESA;
                end
                ATTESA: begin
                    if (MANCHE_VALID) begin
                        verdetto_n = MANCHE_IN;
                        stato_n    = AGGIORNA;
                    end else if (tcnt == TLAST) begin
                        errore_n   = 1'b1;
                        verdetto_n = 2'b00;
                        stato_n    = AGGIORNA;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
                AGGIORNA: begin
                    slot1_n = '0;
                    slot2_n = '0;
                    mg_n    = mg_agg;
                    w1_n    = w1_agg;
                    w2_n    = w2_agg;
                    if (chiude) begin
                        esito_n = esito_agg;
                        stato_n = FINE_PARTITA;
                    end else begin
                        stato_n = RACCOLTA;
                    end
                end
                FINE_PARTITA: begin
                    pp_n = pp_fine;
                    ps_n = ps_fine;
                    pg_n = pg_fine;
                    mg_n = '0;
                    w1_n = '0;
                    w2_n = '0;
                    if (pg_fine == n_tot) begin
                        if (pp_fine > ps_fine)      torneo_n = 2'b01;
                        else if (pp_fine < ps_fine) torneo_n = 2'b10;
                        else                        torneo_n = 2'b11;
                        stato_n = FINE;
                    end else begin
                        stato_n = RACCOLTA;
                    end
                end
                default: ;
            endcase
        end

        P1_READY        = (stato == RACCOLTA) && (slot1 == 2'b00);
        P2_READY        = (stato == RACCOLTA) && (slot2 == 2'b00);
        MOSSA_VALID     = (stato == INVIO);
        MOSSA_PRIMO     = (stato == INVIO) ? slot1 : 2'b00;
        MOSSA_SECONDO   = (stato == INVIO) ? slot2 : 2'b00;
        PARTITA_VALID   = (stato == FINE_PARTITA);
        PARTITA         = (stato == FINE_PARTITA) ? esito : 2'b00;
        MANCHE_GIOCATE  = mg;
        PARTITE_PRIMO   = pp;
        PARTITE_SECONDO = ps;
        TORNEO          = torneo;
        TORNEO_FINE     = (stato == FINE);
        ERRORE          = errore;
    end

endmodule

// File: tb/tb_morra_controllo_torneo.sv
// Directed bench for morra_controllo_torneo: table of rounds with hand-computed
// expectations plus hand-written handshake, timeout, restart and reset sequences.
module tb_morra_controllo_torneo;

    logic       clk = 1'b0;
    logic       rst, INIZIA;
    logic [3:0] CFG_PARTITE;
    logic       P1_VALID, P1_READY, P2_VALID, P2_READY;
    logic [1:0] P1_MOSSA, P2_MOSSA;
    logic       MOSSA_VALID;
    logic [1:0] MOSSA_PRIMO, MOSSA_SECONDO;
    logic       MANCHE_VALID;
    logic [1:0] MANCHE_IN;
    logic [1:0] PARTITA;
    logic       PARTITA_VALID;
    logic [4:0] MANCHE_GIOCATE, PARTITE_PRIMO, PARTITE_SECONDO;
    logic [1:0] TORNEO;
    logic       TORNEO_FINE, ERRORE;

    always #5 clk = ~clk;

    morra_controllo_torneo #(
        .MIN_MANCHE(4),
        .MAX_MANCHE(20),
        .SCARTO(2),
        .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .INIZIA(INIZIA), .CFG_PARTITE(CFG_PARTITE),
        .P1_VALID(P1_VALID), .P1_MOSSA(P1_MOSSA), .P1_READY(P1_READY),
        .P2_VALID(P2_VALID), .P2_MOSSA(P2_MOSSA), .P2_READY(P2_READY),
        .MOSSA_VALID(MOSSA_VALID), .MOSSA_PRIMO(MOSSA_PRIMO), .MOSSA_SECONDO(MOSSA_SECONDO),
        .MANCHE_VALID(MANCHE_VALID), .MANCHE_IN(MANCHE_IN),
        .PARTITA(PARTITA), .PARTITA_VALID(PARTITA_VALID),
        .MANCHE_GIOCATE(MANCHE_GIOCATE), .PARTITE_PRIMO(PARTITE_PRIMO),
        .PARTITE_SECONDO(PARTITE_SECONDO), .TORNEO(TORNEO), .TORNEO_FINE(TORNEO_FINE),
        .ERRORE(ERRORE)
    );

    typedef struct {
        logic [1:0] m1, m2, verd;
        int         mg;
        logic       pv;
        logic [1:0] partita;
        logic       fine;
        logic [1:0] torneo;
        int         pp, ps;
    } row_t;

    row_t tab[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] v,
                                input int mg, input logic pv, input logic [1:0] partita,
                                input logic fine, input logic [1:0] torneo, input int pp, input int ps);
        row_t r;
        r.m1 = m1; r.m2 = m2; r.verd = v; r.mg = mg; r.pv = pv; r.partita = partita;
        r.fine = fine; r.torneo = torneo; r.pp = pp; r.ps = ps;
        tab.push_back(r);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] cfg);
        INIZIA = 1'b1;
        CFG_PARTITE = cfg;
        step();
        INIZIA = 1'b0;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 50 && !(P1_READY && P2_READY); k++) step();
        chk("ready_wait", int'(P1_READY && P2_READY), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_p1_ready"}, P1_READY, 0);
        chk({tag, "_p2_ready"}, P2_READY, 0);
        chk({tag, "_mossa_valid"}, MOSSA_VALID, 0);
        chk({tag, "_partita_valid"}, PARTITA_VALID, 0);
        chk({tag, "_partita"}, PARTITA, 0);
        chk({tag, "_manche"}, MANCHE_GIOCATE, 0);
        chk({tag, "_pp"}, PARTITE_PRIMO, 0);
        chk({tag, "_ps"}, PARTITE_SECONDO, 0);
        chk({tag, "_torneo"}, TORNEO, 0);
        chk({tag, "_torneo_fine"}, TORNEO_FINE, 0);
        chk({tag, "_errore"}, ERRORE, 0);
    endtask

    // One round: both moves in one cycle, verdict in the first ATTESA cycle
    task automatic do_round(input row_t r, input int idx);
        string t;
        t = $sformatf("row%0d", idx);
        wait_ready();
        P1_VALID = 1'b1; P1_MOSSA = r.m1;
        P2_VALID = 1'b1; P2_MOSSA = r.m2;
        step();
        P1_VALID = 1'b0; P2_VALID = 1'b0;
        chk({t, "_mossa_valid"}, MOSSA_VALID, 1);
        chk({t, "_primo"}, MOSSA_PRIMO, r.m1);
        chk({t, "_secondo"}, MOSSA_SECONDO, r.m2);
        step();
        MANCHE_VALID = 1'b1; MANCHE_IN = r.verd;
        step();
        MANCHE_VALID = 1'b0; MANCHE_IN = 2'b00;
        step();
        chk({t, "_partita_valid"}, PARTITA_VALID, r.pv);
        chk({t, "_partita"}, PARTITA, r.pv ? r.partita : 2'b00);
        chk({t, "_manche"}, MANCHE_GIOCATE, r.mg);
        if (PARTITA_VALID) begin
            step();
            chk({t, "_pv_pulse"}, PARTITA_VALID, 0);
            chk({t, "_manche_clr"}, MANCHE_GIOCATE, 0);
            chk({t, "_pp"}, PARTITE_PRIMO, r.pp);
            chk({t, "_ps"}, PARTITE_SECONDO, r.ps);
            chk({t, "_fine"}, TORNEO_FINE, r.fine);
            chk({t, "_torneo"}, TORNEO, r.fine ? r.torneo : 2'b00);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) do_round(tab[i], i);
    endtask

    initial begin
        int a_lo, c_lo, d_lo, e0_lo, e_lo, f_lo, f_hi;
        int err_at, mv_cnt;

        // A: four P1 wins close a single-partita tournament at the minimum
        a_lo = tab.size();
        add(2'b01, 2'b11, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        add(2'b10, 2'b01, 2'b01, 2, 0, 0, 0, 0, 0, 0);
        add(2'b11, 2'b10, 2'b01, 3, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b11, 2'b01, 4, 1, 2'b01, 1, 2'b01, 1, 0);
        // C: alternating wins never build a lead of 2, cap at 20 gives a draw
        c_lo = tab.size();
        for (int i = 0; i < 20; i++)
            add(2'b10, 2'b10, (i % 2 == 0) ? 2'b01 : 2'b10, i + 1, (i == 19), 2'b11,
                (i == 19), 2'b11, 0, 0);
        // D: void verdict does not count
        d_lo = tab.size();
        add(2'b01, 2'b11, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b01, 2'b00, 1, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b11, 2'b01, 2, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b11, 2'b01, 3, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b11, 2'b01, 4, 1, 2'b01, 1, 2'b01, 1, 0);
        // E: two P1 wins, then a restart
        e0_lo = tab.size();
        add(2'b01, 2'b11, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b11, 2'b01, 2, 0, 0, 0, 0, 0, 0);
        // E after restart with 4 partite
        e_lo = tab.size();
        add(2'b01, 2'b11, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b11, 2'b01, 2, 0, 0, 0, 0, 0, 0);
        add(2'b11, 2'b01, 2'b10, 3, 0, 0, 0, 0, 0, 0);
        add(2'b11, 2'b01, 2'b10, 4, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b11, 2'b01, 5, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b11, 2'b01, 6, 1, 2'b01, 0, 0, 1, 0);
        add(2'b11, 2'b01, 2'b10, 1, 0, 0, 0, 0, 0, 0);
        add(2'b11, 2'b01, 2'b10, 2, 0, 0, 0, 0, 0, 0);
        add(2'b11, 2'b01, 2'b10, 3, 0, 0, 0, 0, 0, 0);
        add(2'b11, 2'b01, 2'b10, 4, 1, 2'b10, 0, 0, 1, 1);
        add(2'b01, 2'b11, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        add(2'b11, 2'b01, 2'b10, 2, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b11, 2'b01, 3, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b11, 2'b01, 4, 1, 2'b01, 0, 0, 2, 1);
        add(2'b11, 2'b01, 2'b10, 1, 0, 0, 0, 0, 0, 0);
        add(2'b10, 2'b10, 2'b11, 2, 0, 0, 0, 0, 0, 0);
        add(2'b11, 2'b01, 2'b10, 3, 0, 0, 0, 0, 0, 0);
        add(2'b11, 2'b01, 2'b10, 4, 1, 2'b10, 1, 2'b11, 2, 2);
        // F: first of two partite, then reset mid-round
        f_lo = tab.size();
        add(2'b01, 2'b11, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b11, 2'b01, 2, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b11, 2'b01, 3, 0, 0, 0, 0, 0, 0);
        add(2'b01, 2'b11, 2'b01, 4, 1, 2'b01, 0, 0, 1, 0);
        f_hi = tab.size();

        rst = 1'b1; INIZIA = 1'b0; CFG_PARTITE = '0;
        P1_VALID = 1'b0; P1_MOSSA = '0; P2_VALID = 1'b0; P2_MOSSA = '0;
        MANCHE_VALID = 1'b0; MANCHE_IN = '0;
        step();
        step();
        rst = 1'b0;
        chk_all_zero("reset");
        step();
        chk("idle_p1_ready", P1_READY, 0);

        start(4'd0);
        run_rows(a_lo, c_lo);
        step();
        chk("fine_held", TORNEO_FINE, 1);
        chk("fine_held_torneo", TORNEO, 1);

        // B: 00 move dropped, staggered accepts, verdict during INVIO ignored, then timeout
        start(4'd0);
        P1_VALID = 1'b1; P1_MOSSA = 2'b00;
        chk("b_p1_ready0", P1_READY, 1);
        step();
        P1_MOSSA = 2'b10;
        chk("b_p1_ready_after00", P1_READY, 1);
        step();
        P1_MOSSA = 2'b01;
        chk("b_p1_ready_full", P1_READY, 0);
        P2_VALID = 1'b1; P2_MOSSA = 2'b11;
        chk("b_p2_ready", P2_READY, 1);
        chk("b_no_issue_yet", MOSSA_VALID, 0);
        step();
        P1_VALID = 1'b0; P2_VALID = 1'b0;
        chk("b_mossa_valid", MOSSA_VALID, 1);
        chk("b_primo", MOSSA_PRIMO, 2);
        chk("b_secondo", MOSSA_SECONDO, 3);
        MANCHE_VALID = 1'b1; MANCHE_IN = 2'b01;
        err_at = -1;
        mv_cnt = 0;
        for (int i = 1; i <= 20 && err_at < 0; i++) begin
            step();
            if (i == 1) begin
                MANCHE_VALID = 1'b0; MANCHE_IN = 2'b00;
            end
            if (MOSSA_VALID) mv_cnt++;
            if (ERRORE) err_at = i;
        end
        chk("b_timeout_cycle", err_at, 9);
        chk("b_single_issue", mv_cnt, 0);
        chk("b_manche_unchanged", MANCHE_GIOCATE, 0);
        step();
        chk("b_errore_pulse", ERRORE, 0);
        chk("b_p1_ready_back", P1_READY, 1);
        chk("b_p2_ready_back", P2_READY, 1);

        start(4'd0);
        run_rows(c_lo, d_lo);
        start(4'd0);
        run_rows(d_lo, e0_lo);

        start(4'd0);
        run_rows(e0_lo, e_lo);
        start(4'd3);
        chk("e_restart_manche", MANCHE_GIOCATE, 0);
        chk("e_restart_pp", PARTITE_PRIMO, 0);
        chk("e_restart_p1_ready", P1_READY, 1);
        chk("e_restart_p2_ready", P2_READY, 1);
        run_rows(e_lo, f_lo);

        start(4'd1);
        run_rows(f_lo, f_hi);
        chk("f_not_done", TORNEO_FINE, 0);
        wait_ready();
        P1_VALID = 1'b1; P1_MOSSA = 2'b01;
        P2_VALID = 1'b1; P2_MOSSA = 2'b10;
        step();
        P1_VALID = 1'b0; P2_VALID = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("f_rst");
        P1_VALID = 1'b1; P1_MOSSA = 2'b01;
        step();
        chk("f_idle_ready", P1_READY, 0);
        chk("f_idle_no_issue", MOSSA_VALID, 0);
        P1_VALID = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/morra_controllo_torneo.md
Name: morra_controllo_torneo

Overview:
- Sequencer/controller for the morra cinese round evaluator.
- Loads the tournament configuration and collects one move per player through valid/ready handshakes.
- Issues each move pair to the evaluator, consumes its round verdict, and tracks manche and partite.
- Declares the winner of each partita and of the tournament; sits between the player input logic and the evaluator.

Parameters:
MIN_MANCHE, 4, valid rounds required before a lead can close a partita
MAX_MANCHE, 20, valid-round cap per partita
SCARTO, 2, lead (in won manche) that closes a partita
TIMEOUT, 8, cycles allowed for the evaluator verdict after issue

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
INIZIA  in  1  start/restart pulse; samples CFG_PARTITE
CFG_PARTITE  in  4  partite to play minus 1 (1..16)
P1_VALID  in  1  player 1 move offered
P1_MOSSA  in  2  player 1 move: 01 sasso, 10 carta, 11 forbice, 00 none
P1_READY  out  1  controller accepts player 1 move
P2_VALID, P2_MOSSA, P2_READY  as player 1, for player 2
MOSSA_VALID  out  1  one-cycle issue strobe to evaluator
MOSSA_PRIMO, MOSSA_SECONDO  out  2 each  move pair, valid with MOSSA_VALID
MANCHE_VALID  in  1  evaluator verdict strobe
MANCHE_IN  in  2  00 void, 01 primo, 10 secondo, 11 pareggio
PARTITA  out  2  00 in corso, 01/10/11 winner/draw; valid with PARTITA_VALID
PARTITA_VALID  out  1  one-cycle partita-end strobe
MANCHE_GIOCATE  out  5  valid rounds in current partita
PARTITE_PRIMO, PARTITE_SECONDO  out  5 each  partite won
TORNEO  out  2  tournament result, held in FINE
TORNEO_FINE  out  1  high while in FINE
ERRORE  out  1  one-cycle pulse on evaluator timeout

Behaviour:
- Reset (rst high at posedge, priority over everything): state IDLE. All outputs 0, all counters 0, slots empty.
- INIZIA high (not rst), any state:
  - Load N = CFG_PARTITE+1.
  - Clear manche counters, partite counters, slots and TORNEO.
  - Next state RACCOLTA.
- States:
  - IDLE: READYs 0; wait for INIZIA.
  - RACCOLTA:
    - Px_READY = 1 while slot x is empty.
    - A transfer happens on Px_VALID & Px_READY. A nonzero move fills the slot; 00 is consumed and dropped (slot stays empty).
    - Both players may transfer in the same cycle.
    - When both slots are full, go to INVIO on the next edge.
  - INVIO:
    - One cycle; MOSSA_VALID=1 with the slot contents; READYs 0.
    - Go to ATTESA and start the timeout counter at 0.
  - ATTESA:
    - MANCHE_VALID is sampled only here; a verdict in the INVIO cycle is ignored.
    - On MANCHE_VALID, register the verdict and go to AGGIORNA.
    - If the timeout counter reaches TIMEOUT without a verdict, pulse ERRORE and treat the verdict as 00.
  - AGGIORNA:
    - Verdict 00: no counter change; clear slots; return to RACCOLTA.
    - Verdict otherwise: MANCHE_GIOCATE+1; 01 → w1+1, 10 → w2+1, 11 → no win counted; clear slots.
    - Close the partita (go to FINE_PARTITA) if either condition holds:
      - MANCHE_GIOCATE ≥ MIN_MANCHE and |w1−w2| ≥ SCARTO → winner is the leader.
      - MANCHE_GIOCATE == MAX_MANCHE → winner is the player with more wins, 11 if equal.
    - Otherwise return to RACCOLTA.
    - Compute with the post-update values (one-cycle combinational check on next values).
  - FINE_PARTITA:
    - One cycle; PARTITA and PARTITA_VALID=1.
    - Increment PARTITE_PRIMO/SECONDO for a win; neither on a draw. Partite played +1.
    - Clear MANCHE_GIOCATE, w1 and w2.
    - If partite played == N, go to FINE; else go to RACCOLTA.
  - FINE:
    - TORNEO_FINE=1; TORNEO = 01 if PARTITE_PRIMO > PARTITE_SECONDO, 10 if less, 11 if equal.
    - Held until INIZIA or rst.
- PARTITA is 00 whenever PARTITA_VALID=0.
- Counters never wrap: max 20 manche, 16 partite.
- Minimum round latency: both moves accepted at edge k, MOSSA_VALID during cycle k+1, earliest verdict sampled at edge k+2.

Test Plan:
- rst, INIZIA with CFG_PARTITE=0; rounds with verdicts 01,01,01,01 → MANCHE_GIOCATE 4 at close; PARTITA=01 with one PARTITA_VALID pulse; then TORNEO_FINE=1, TORNEO=01.
- P1 offers 00 then 10, P2 offers 11 one cycle later → MOSSA_VALID exactly once with MOSSA_PRIMO=10, MOSSA_SECONDO=11; P1_READY low after the first nonzero accept.
- Verdicts alternating 01/10 for 20 rounds → PARTITA=11 at round 20; both partite counters stay 0.
- Evaluator silent after issue → ERRORE pulses after TIMEOUT=8 cycles; MANCHE_GIOCATE unchanged; controller back in RACCOLTA with READYs high.
- Verdict 00 mixed in (01,00,01,01,01) → closes at the 4th valid round, PARTITA=01.
- INIZIA mid-partita with 2 manche won, CFG_PARTITE=3 → all counters 0, state RACCOLTA; tournament ends only after 4 partite; rst mid-ATTESA → IDLE, all outputs 0.
